adc_scope_capture: RTL

Trigger and capture controller for the ADC scope path. It watches the LTC2308 sample stream, which signals each new sample with a toggle on `adc_sync`. It sequences pre-trigger fill, trigger search and post-trigger capture into a double-buffered sample RAM, then hands a completed, trigger-aligned frame to the video renderer. The block sits between the ADC sample register in `emu` and `adctest`, which reads the displayed frame by sample index.

---
 rtl/adc_scope_capture.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/adc_scope_capture.sv
// adc_scope_capture: trigger/capture controller for the ADC scope path.
// Double-buffered N x 12 sample RAM, pre-trigger fill, trigger search,
// post-trigger capture, and a trigger-aligned registered read port.
// Ports:
//   clk, reset        - single clock, synchronous active-high reset
//   adc_data/adc_sync - sample value and per-sample toggle strobe
//   trig_level/edge   - threshold and slope (0 rising, 1 falling)
//   trig_mode/arm     - 0 auto, 1 normal, 2 single, 3 normal; arm pulse
//   rd_addr/rd_data   - display read port, index 0 = oldest sample
//   frame_ready       - one-cycle pulse when a new frame is visible
//   cap_state         - 0 IDLE, 1 PRE, 2 WAIT, 3 POST/DONE
//   forced            - displayed frame was auto-forced
module adc_scope_capture #(
    parameter int DEPTH_LOG2   = 9,
    parameter int PRETRIG      = 64,
    parameter int AUTO_SAMPLES = 4800
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [11:0]           adc_data,
    input  logic                  adc_sync,
    input  logic [11:0]           trig_level,
    input  logic                  trig_edge,
    input  logic [1:0]            trig_mode,
    input  logic                  arm,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [11:0]           rd_data,
    output logic                  frame_ready,
    output logic [1:0]            cap_state,
    output logic                  forced
);

    localparam int N    = 1 << DEPTH_LOG2;
    localparam int AW   = DEPTH_LOG2;
    localparam int MAXC = (AUTO_SAMPLES > N) ? AUTO_SAMPLES : N;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] PRE_LAST  = CW'(PRETRIG - 1);
    localparam logic [CW-1:0] AUTO_LAST = CW'(AUTO_SAMPLES - 1);
    localparam logic [CW-1:0] POST_LAST = CW'(N - PRETRIG - 2);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRETRIG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   prev_q, prev_d;
    logic [AW-1:0] ta_q, ta_d;
    logic          f_q, f_d;
    logic          wb_q, wb_d;
    logic [AW-1:0] disp_start_q, disp_start_d;
    logic          forced_q, forced_d;
    logic          frame_ready_q, frame_ready_d;
    logic          sync_q;
    logic [11:0]   rd_data_q;

    logic [11:0]   mem [0:2*N-1];

    logic          ev;
    logic          wr_en;
    logic          trig_hit;
    logic          auto_mode;
    logic [AW-1:0] rd_idx;

    assign ev        = sync_q ^ adc_sync;
    assign auto_mode = (trig_mode == 2'd0);
    assign wr_en     = ev && (state_q == S_PRE || state_q == S_WAIT
                              || state_q == S_POST);
    assign rd_idx    = disp_start_q + rd_addr;

    always_comb begin
        if (trig_edge)
            trig_hit = (prev_q >= trig_level) && (adc_data < trig_level);
        else
            trig_hit = (prev_q < trig_level) && (adc_data >= trig_level);
    end

    always_comb begin
        state_d       = state_q;
        wp_d          = wp_q;
        cnt_d         = cnt_q;
        prev_d        = prev_q;
        ta_d          = ta_q;
        f_d           = f_q;
        wb_d          = wb_q;
        disp_start_d  = disp_start_q;
        forced_d      = forced_q;
        frame_ready_d = 1'b0;

        if (wr_en) begin
            wp_d   = wp_q + AW'(1);
            prev_d = adc_data;
        end

        unique case (state_q)
            S_IDLE: begin
                if (trig_mode != 2'd2 || arm) begin
                    state_d = S_PRE;
                    wp_d    = '0;
                    cnt_d   = '0;
                end
            end
            S_PRE: begin
                if (ev) begin
                    if (cnt_q == PRE_LAST) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (ev) begin
                    if (trig_hit) begin
                        ta_d    = wp_q;
                        f_d     = 1'b0;
                        state_d = S_POST;
                        cnt_d   = '0;
                    end else if (auto_mode) begin
                        // Timeout sample itself becomes the trigger.
                        if (cnt_q == AUTO_LAST) begin
                            ta_d    = wp_q;
                            f_d     = 1'b1;
                            state_d = S_POST;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end else if (!auto_mode) begin
                    cnt_d = '0;
                end
            end
            S_POST: begin
                if (ev) begin
                    if (cnt_q == POST_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DONE: begin
                wb_d          = ~wb_q;
                disp_start_d  = ta_q - PRE_OFS;
                forced_d      = f_q;
                frame_ready_d = 1'b1;
                if (trig_mode == 2'd2) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_PRE;
                    wp_d    = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // Tracking adc_sync through reset avoids a bogus first event.
        sync_q <= adc_sync;
        if (reset) begin
            state_q       <= S_IDLE;
            wp_q          <= '0;
            cnt_q         <= '0;
            prev_q        <= '0;
            ta_q          <= '0;
            f_q           <= 1'b0;
            wb_q          <= 1'b0;
            disp_start_q  <= '0;
            forced_q      <= 1'b0;
            frame_ready_q <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            wp_q          <= wp_d;
            cnt_q         <= cnt_d;
            prev_q        <= prev_d;
            ta_q          <= ta_d;
            f_q           <= f_d;
            wb_q          <= wb_d;
            disp_start_q  <= disp_start_d;
            forced_q      <= forced_d;
            frame_ready_q <= frame_ready_d;
            rd_data_q     <= mem[{~wb_q, rd_idx}];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset)
            mem[{wb_q, wp_q}] <= adc_data;
    end

    always_comb begin
        unique case (state_q)
            S_IDLE:  cap_state = 2'd0;
            S_PRE:   cap_state = 2'd1;
            S_WAIT:  cap_state = 2'd2;
            default: cap_state = 2'd3;
        endcase
    end

    assign rd_data     = rd_data_q;
    assign frame_ready = frame_ready_q;
    assign forced      = forced_q;

endmodule
